decode_stage: RTL and testbench

- Instruction-decode (ID) stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the 32x32 register file: drives its two read addresses from the fetched instruction and captures the returned operands.
- Decodes a MIPS-I integer subset into control fields and registers everything into the ID/EX pipeline register.
- Owns load-use hazard detection (stall + bubble), EX back-pressure and branch flush.

---
 rtl/decode_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register-file operand capture, load-use stall and flush into the ID/EX register.
// Optional macro DECODE_STALL_COUNTER_EN enables a saturating stall counter on perf_stall_cnt.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_stall,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [4:0]  rf_read1_addr,
  output logic [4:0]  rf_read2_addr,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [4:0]  ex_rs_addr,
  output logic [4:0]  ex_rt_addr,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic [2:0]  ex_ctrl,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_illegal,
  output logic [31:0] perf_stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [2:0]  ctrl;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } id_ex_t;

  typedef enum logic {RUN, STALL} state_t;

  function automatic id_ex_t bubble();
    id_ex_t b;
    b       = '0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

  logic [5:0]  op_p0, fn_p0;
  logic [4:0]  rs_p0, rt_p0, rd_p0;
  logic [4:0]  dest_p0;
  logic [31:0] imm_p0;
  logic [3:0]  alu_op_p0;
  logic        src_imm_p0, is_load_p0, is_store_p0, illegal_p0;
  logic [2:0]  ctrl_p0;
  logic        uses_rs_p0, uses_rt_p0;
  logic        load_hz, hz_en;
  id_ex_t      dec_p0, ex_p1;
  state_t      state, state_nxt;

  assign op_p0 = if_instr[31:26];
  assign rs_p0 = if_instr[25:21];
  assign rt_p0 = if_instr[20:16];
  assign rd_p0 = if_instr[15:11];
  assign fn_p0 = if_instr[5:0];

  assign rf_read1_addr = rs_p0;
  assign rf_read2_addr = rt_p0;

  // Stage p0: combinational decode of the instruction sitting in ID
  always_comb begin
    dest_p0     = 5'd0;
    imm_p0      = sext16(if_instr[15:0]);
    alu_op_p0   = 4'd0;
    src_imm_p0  = 1'b0;
    ctrl_p0     = 3'd0;
    is_load_p0  = 1'b0;
    is_store_p0 = 1'b0;
    illegal_p0  = 1'b0;
    uses_rs_p0  = 1'b1;
    uses_rt_p0  = 1'b0;
    case (op_p0)
      6'h00: begin
        uses_rt_p0 = 1'b1;
        dest_p0    = rd_p0;
        case (fn_p0)
          6'h21: alu_op_p0 = 4'd0;
          6'h23: alu_op_p0 = 4'd1;
          6'h24: alu_op_p0 = 4'd2;
          6'h25: alu_op_p0 = 4'd3;
          6'h26: alu_op_p0 = 4'd4;
          6'h27: alu_op_p0 = 4'd5;
          6'h2A: alu_op_p0 = 4'd6;
          6'h2B: alu_op_p0 = 4'd7;
          6'h00, 6'h02, 6'h03: begin
            alu_op_p0  = (fn_p0 == 6'h00) ? 4'd8 : (fn_p0 == 6'h02) ? 4'd9 : 4'd10;
            imm_p0     = {27'h0, if_instr[10:6]};
            uses_rs_p0 = 1'b0;
          end
          6'h08: begin
            ctrl_p0 = 3'd5;
            dest_p0 = 5'd0;
          end
          default: begin
            illegal_p0 = 1'b1;
            dest_p0    = 5'd0;
          end
        endcase
      end
      6'h09: begin alu_op_p0 = 4'd0; src_imm_p0 = 1'b1; dest_p0 = rt_p0; end
      6'h0A: begin alu_op_p0 = 4'd6; src_imm_p0 = 1'b1; dest_p0 = rt_p0; end
      6'h0B: begin alu_op_p0 = 4'd7; src_imm_p0 = 1'b1; dest_p0 = rt_p0; end
      6'h0C: begin alu_op_p0 = 4'd2; src_imm_p0 = 1'b1; dest_p0 = rt_p0; imm_p0 = zext16(if_instr[15:0]); end
      6'h0D: begin alu_op_p0 = 4'd3; src_imm_p0 = 1'b1; dest_p0 = rt_p0; imm_p0 = zext16(if_instr[15:0]); end
      6'h0E: begin alu_op_p0 = 4'd4; src_imm_p0 = 1'b1; dest_p0 = rt_p0; imm_p0 = zext16(if_instr[15:0]); end
      6'h0F: begin
        alu_op_p0  = 4'd11;
        src_imm_p0 = 1'b1;
        dest_p0    = rt_p0;
        imm_p0     = {if_instr[15:0], 16'h0};
        uses_rs_p0 = 1'b0;
      end
      6'h23: begin is_load_p0 = 1'b1; src_imm_p0 = 1'b1; dest_p0 = rt_p0; end
      6'h2B: begin is_store_p0 = 1'b1; src_imm_p0 = 1'b1; uses_rt_p0 = 1'b1; end
      6'h04: begin ctrl_p0 = 3'd1; alu_op_p0 = 4'd1; uses_rt_p0 = 1'b1; end
      6'h05: begin ctrl_p0 = 3'd2; alu_op_p0 = 4'd1; uses_rt_p0 = 1'b1; end
      6'h02, 6'h03: begin
        ctrl_p0    = (op_p0 == 6'h02) ? 3'd3 : 3'd4;
        dest_p0    = (op_p0 == 6'h02) ? 5'd0 : 5'd31;
        imm_p0     = {6'h0, if_instr[25:0]};
        uses_rs_p0 = 1'b0;
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  always_comb begin
    dec_p0             = '0;
    dec_p0.valid       = 1'b1;
    dec_p0.pc          = if_pc;
    dec_p0.instr       = if_instr;
    dec_p0.rs_val      = rf_data1;
    dec_p0.rt_val      = rf_data2;
    dec_p0.imm         = imm_p0;
    dec_p0.rs_addr     = uses_rs_p0 ? rs_p0 : 5'd0;
    dec_p0.rt_addr     = uses_rt_p0 ? rt_p0 : 5'd0;
    dec_p0.dest        = dest_p0;
    dec_p0.alu_op      = alu_op_p0;
    dec_p0.alu_src_imm = src_imm_p0;
    dec_p0.ctrl        = ctrl_p0;
    dec_p0.is_load     = is_load_p0;
    dec_p0.is_store    = is_store_p0;
    dec_p0.illegal     = illegal_p0;
  end

  // In STALL the ID/EX register holds a bubble, so hazard detection is only meaningful in RUN
  assign load_hz = hz_en & ex_p1.valid & ex_p1.is_load & (ex_p1.dest != 5'd0) &
                   ((uses_rs_p0 & (ex_p1.dest == rs_p0)) | (uses_rt_p0 & (ex_p1.dest == rt_p0)));
  assign id_stall = if_valid & ~flush & (load_hz | ~ex_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!flush && ex_ready && load_hz) state_nxt = STALL;
      STALL:   if (flush || ex_ready)             state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    hz_en = (state == RUN);
  end

  // Stage p1: ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst)                      ex_p1 <= bubble();
    else if (flush)               ex_p1 <= bubble();
    else if (!ex_ready)           ex_p1 <= ex_p1;
    else if (load_hz || !if_valid) ex_p1 <= bubble();
    else                          ex_p1 <= dec_p0;
  end

  assign ex_valid       = ex_p1.valid;
  assign ex_pc          = ex_p1.pc;
  assign ex_instr       = ex_p1.instr;
  assign ex_rs_val      = ex_p1.rs_val;
  assign ex_rt_val      = ex_p1.rt_val;
  assign ex_rs_addr     = ex_p1.rs_addr;
  assign ex_rt_addr     = ex_p1.rt_addr;
  assign ex_imm         = ex_p1.imm;
  assign ex_dest        = ex_p1.dest;
  assign ex_alu_op      = ex_p1.alu_op;
  assign ex_alu_src_imm = ex_p1.alu_src_imm;
  assign ex_ctrl        = ex_p1.ctrl;
  assign ex_is_load     = ex_p1.is_load;
  assign ex_is_store    = ex_p1.is_store;
  assign ex_illegal     = ex_p1.illegal;

`ifdef DECODE_STALL_COUNTER_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst)           stall_cnt <= 32'd0;
    else if (id_stall) stall_cnt <= sat_inc(stall_cnt);
  end
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: fixed vectors, hand-written hazard/flush sequences and a random run vs a cycle model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready, id_stall;
  logic [31:0] if_instr, if_pc, rf_data1, rf_data2;
  logic [4:0]  rf_read1_addr, rf_read2_addr;
  logic        ex_valid, ex_alu_src_imm, ex_is_load, ex_is_store, ex_illegal;
  logic [31:0] ex_pc, ex_instr, ex_rs_val, ex_rt_val, ex_imm, perf_stall_cnt;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_ctrl;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_stall(id_stall), .flush(flush), .ex_ready(ex_ready),
    .rf_read1_addr(rf_read1_addr), .rf_read2_addr(rf_read2_addr),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_illegal(ex_illegal), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA, M_JR,
                M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
                M_J, M_JAL, M_ILL} m_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, rs_val, rt_val, imm;
    logic [4:0]  rs_addr, rt_addr, dest;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic [2:0]  ctrl;
    logic        is_load, is_store, illegal;
    logic        uses_rs, uses_rt;
  } exp_t;

  typedef struct {
    logic [31:0] instr, d1, d2;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  ctrl;
    logic        ill;
    logic [4:0]  rsa, rta;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic m_t classify(input logic [31:0] i);
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h21: return M_ADDU;  6'h23: return M_SUBU; 6'h24: return M_AND;  6'h25: return M_OR;
        6'h26: return M_XOR;   6'h27: return M_NOR;  6'h2A: return M_SLT;  6'h2B: return M_SLTU;
        6'h00: return M_SLL;   6'h02: return M_SRL;  6'h03: return M_SRA;  6'h08: return M_JR;
        default: return M_ILL;
      endcase
      6'h09: return M_ADDIU; 6'h0A: return M_SLTI; 6'h0B: return M_SLTIU; 6'h0C: return M_ANDI;
      6'h0D: return M_ORI;   6'h0E: return M_XORI; 6'h0F: return M_LUI;   6'h23: return M_LW;
      6'h2B: return M_SW;    6'h04: return M_BEQ;  6'h05: return M_BNE;   6'h02: return M_J;
      6'h03: return M_JAL;
      default: return M_ILL;
    endcase
  endfunction

  function automatic exp_t empty_slot();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    m_t   m;
    m = classify(i);
    e = empty_slot();
    e.valid = 1'b1; e.pc = pc; e.instr = i; e.rs_val = d1; e.rt_val = d2;
    e.uses_rs = !(m inside {M_LUI, M_J, M_JAL, M_SLL, M_SRL, M_SRA});
    e.uses_rt = (i[31:26] == 6'h00) || (m inside {M_SW, M_BEQ, M_BNE});
    e.rs_addr = e.uses_rs ? i[25:21] : 5'd0;
    e.rt_addr = e.uses_rt ? i[20:16] : 5'd0;
    if (m inside {M_ANDI, M_ORI, M_XORI})       e.imm = i[15:0];
    else if (m == M_LUI)                        e.imm = i[15:0] << 16;
    else if (m inside {M_SLL, M_SRL, M_SRA})    e.imm = i[10:6];
    else if (m inside {M_J, M_JAL})             e.imm = i[25:0];
    else                                        e.imm = $signed(i[15:0]);
    if (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA})
      e.dest = i[15:11];
    else if (m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW})
      e.dest = i[20:16];
    else if (m == M_JAL)
      e.dest = 5'd31;
    case (m)
      M_SUBU, M_BEQ, M_BNE: e.alu_op = 1;
      M_AND, M_ANDI:        e.alu_op = 2;
      M_OR, M_ORI:          e.alu_op = 3;
      M_XOR, M_XORI:        e.alu_op = 4;
      M_NOR:                e.alu_op = 5;
      M_SLT, M_SLTI:        e.alu_op = 6;
      M_SLTU, M_SLTIU:      e.alu_op = 7;
      M_SLL:                e.alu_op = 8;
      M_SRL:                e.alu_op = 9;
      M_SRA:                e.alu_op = 10;
      M_LUI:                e.alu_op = 11;
      default:              e.alu_op = 0;
    endcase
    e.src_imm  = m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW};
    e.ctrl     = (m == M_BEQ) ? 3'd1 : (m == M_BNE) ? 3'd2 : (m == M_J) ? 3'd3 :
                 (m == M_JAL) ? 3'd4 : (m == M_JR) ? 3'd5 : 3'd0;
    e.is_load  = (m == M_LW);
    e.is_store = (m == M_SW);
    e.illegal  = (m == M_ILL);
    return e;
  endfunction

  // Load-use rule evaluated on the model's ID/EX slot and the instruction now in ID
  function automatic logic ref_hz(input exp_t slot, input logic [31:0] i);
    exp_t d;
    d = ref_decode(i, 32'h0, 32'h0, 32'h0);
    return slot.valid && slot.is_load && slot.dest != 0 &&
           ((d.uses_rs && slot.dest == i[25:21]) || (d.uses_rt && slot.dest == i[20:16]));
  endfunction

  task automatic cmp_all(input string t, input exp_t e);
    chk({t, ".valid"}, ex_valid, e.valid);
    chk({t, ".pc"}, ex_pc, e.pc);
    chk({t, ".instr"}, ex_instr, e.instr);
    chk({t, ".rs_val"}, ex_rs_val, e.rs_val);
    chk({t, ".rt_val"}, ex_rt_val, e.rt_val);
    chk({t, ".rs_addr"}, ex_rs_addr, e.rs_addr);
    chk({t, ".rt_addr"}, ex_rt_addr, e.rt_addr);
    chk({t, ".imm"}, ex_imm, e.imm);
    chk({t, ".dest"}, ex_dest, e.dest);
    chk({t, ".alu_op"}, ex_alu_op, e.alu_op);
    chk({t, ".src_imm"}, ex_alu_src_imm, e.src_imm);
    chk({t, ".ctrl"}, ex_ctrl, e.ctrl);
    chk({t, ".is_load"}, ex_is_load, e.is_load);
    chk({t, ".is_store"}, ex_is_store, e.is_store);
    chk({t, ".illegal"}, ex_illegal, e.illegal);
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    if_instr = 32'h0; if_pc = 32'h0; rf_data1 = 32'h0; rf_data2 = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = i; if_pc = pc;
  endtask

  localparam logic [31:0] LW4   = 32'h8C44_0000;
  localparam logic [31:0] ADDU6 = 32'h0081_3021;
  localparam logic [31:0] LUI4  = 32'h3C04_1234;
  localparam logic [31:0] ORI2  = 32'h3422_8001;

  vec_t  tbl[11];
  exp_t  m_slot, nxt;
  logic  m_stall, prev_stall, hz;
  logic [31:0] m_cnt, exp_cnt;
  logic [5:0]  ops[19];
  logic [5:0]  fns[13];

  initial begin
    tbl[0]  = '{32'h2465_FFFC, 32'h0000_0010, 32'h1111_1111, 5'd5,  32'hFFFF_FFFC, 4'd0,  3'd0, 1'b0, 5'd3,  5'd0};
    tbl[1]  = '{32'h0C10_0004, 32'h2222_2222, 32'h3333_3333, 5'd31, 32'h0010_0004, 4'd0,  3'd4, 1'b0, 5'd0,  5'd0};
    tbl[2]  = '{32'hFC22_1234, 32'h4444_4444, 32'h5555_5555, 5'd0,  32'h0000_1234, 4'd0,  3'd0, 1'b1, 5'd1,  5'd0};
    tbl[3]  = '{32'h3C04_1234, 32'h6666_6666, 32'h7777_7777, 5'd4,  32'h1234_0000, 4'd11, 3'd0, 1'b0, 5'd0,  5'd0};
    tbl[4]  = '{32'h3422_8001, 32'h8888_8888, 32'h9999_9999, 5'd2,  32'h0000_8001, 4'd3,  3'd0, 1'b0, 5'd1,  5'd0};
    tbl[5]  = '{32'h0002_1943, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd3,  32'h0000_0005, 4'd10, 3'd0, 1'b0, 5'd0,  5'd2};
    tbl[6]  = '{32'hACC5_0008, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 5'd0,  32'h0000_0008, 4'd0,  3'd0, 1'b0, 5'd6,  5'd5};
    tbl[7]  = '{32'h1422_FFFF, 32'h0000_0001, 32'h0000_0002, 5'd0,  32'hFFFF_FFFF, 4'd1,  3'd2, 1'b0, 5'd1,  5'd2};
    tbl[8]  = '{32'h03E0_0008, 32'h0040_0000, 32'h0000_0000, 5'd0,  32'h0000_0008, 4'd0,  3'd5, 1'b0, 5'd31, 5'd0};
    tbl[9]  = '{32'h0022_3823, 32'h0000_0009, 32'h0000_0004, 5'd7,  32'h0000_3823, 4'd1,  3'd0, 1'b0, 5'd1,  5'd2};
    tbl[10] = '{32'h0022_383F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0,  32'h0000_383F, 4'd0,  3'd0, 1'b1, 5'd1,  5'd2};
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};

    // Reset state
    do_reset();
    cmp_all("reset", empty_slot());
    chk("reset.id_stall", id_stall, 1'b0);
    chk("reset.perf", perf_stall_cnt, 32'h0);

    // Fixed decode vectors, each separated by an idle cycle
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      issue(tbl[k].instr, 32'h0040_0000 + 32'(k * 4));
      rf_data1 = tbl[k].d1; rf_data2 = tbl[k].d2;
      @(negedge clk);
      chk($sformatf("vec%0d.valid", k), ex_valid, 1'b1);
      chk($sformatf("vec%0d.dest", k), ex_dest, tbl[k].dest);
      chk($sformatf("vec%0d.imm", k), ex_imm, tbl[k].imm);
      chk($sformatf("vec%0d.alu_op", k), ex_alu_op, tbl[k].alu);
      chk($sformatf("vec%0d.ctrl", k), ex_ctrl, tbl[k].ctrl);
      chk($sformatf("vec%0d.illegal", k), ex_illegal, tbl[k].ill);
      chk($sformatf("vec%0d.rs_addr", k), ex_rs_addr, tbl[k].rsa);
      chk($sformatf("vec%0d.rt_addr", k), ex_rt_addr, tbl[k].rta);
      chk($sformatf("vec%0d.rs_val", k), ex_rs_val, tbl[k].d1);
      chk($sformatf("vec%0d.rt_val", k), ex_rt_val, tbl[k].d2);
      if (k == 0) chk("vec0.src_imm", ex_alu_src_imm, 1'b1);
      if_valid = 1'b0;
    end

    // Load-use: one stall cycle, one bubble, then the consumer
    do_reset();
    @(negedge clk); issue(LW4, 32'h100);
    @(negedge clk); issue(ADDU6, 32'h104);
    #1 chk("lu.stall1", id_stall, 1'b1);
    @(negedge clk);
    chk("lu.bubble", ex_valid, 1'b0);
    #1 chk("lu.stall2", id_stall, 1'b0);
    @(negedge clk);
    chk("lu.valid", ex_valid, 1'b1);
    chk("lu.instr", ex_instr, ADDU6);
    chk("lu.rs_addr", ex_rs_addr, 5'd4);
`ifdef DECODE_STALL_COUNTER_EN
    chk("lu.perf", perf_stall_cnt, 32'd1);
`else
    chk("lu.perf", perf_stall_cnt, 32'd0);
`endif

    // Load then LUI to the same register: no hazard
    issue(LW4, 32'h108);
    @(negedge clk); issue(LUI4, 32'h10C);
    #1 chk("lui.stall", id_stall, 1'b0);
    @(negedge clk);
    chk("lui.valid", ex_valid, 1'b1);
    chk("lui.imm", ex_imm, 32'h1234_0000);
    chk("lui.rs_addr", ex_rs_addr, 5'd0);
    chk("lui.alu_op", ex_alu_op, 4'd11);

    // EX back-pressure for three cycles
    issue(ORI2, 32'h110); ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.stall", k), id_stall, 1'b1);
      @(negedge clk);
      chk($sformatf("bp%0d.instr", k), ex_instr, LUI4);
      chk($sformatf("bp%0d.pc", k), ex_pc, 32'h10C);
    end
    ex_ready = 1'b1;
    #1 chk("bp.release_stall", id_stall, 1'b0);
    @(negedge clk);
    chk("bp.instr", ex_instr, ORI2);
    chk("bp.valid", ex_valid, 1'b1);
    if_valid = 1'b0;

    // Flush while stalled on a load-use
    @(negedge clk); issue(LW4, 32'h200);
    @(negedge clk); issue(ADDU6, 32'h204);
    #1 chk("fl.stall", id_stall, 1'b1);
    @(negedge clk);
    chk("fl.bubble", ex_valid, 1'b0);
    flush = 1'b1;
    #1 chk("fl.stall_flush", id_stall, 1'b0);
    @(negedge clk);
    chk("fl.valid", ex_valid, 1'b0);
    flush = 1'b0; if_valid = 1'b0;
    #1 chk("fl.stall_after", id_stall, 1'b0);
    @(negedge clk);
    chk("fl.not_issued", ex_valid, 1'b0);

    // Flush coinciding with a load-use hazard
    issue(LW4, 32'h300);
    @(negedge clk); issue(ADDU6, 32'h304); flush = 1'b1;
    #1 chk("flhz.stall", id_stall, 1'b0);
    @(negedge clk);
    chk("flhz.valid", ex_valid, 1'b0);
    flush = 1'b0;
    #1 chk("flhz.no_stall", id_stall, 1'b0);
    @(negedge clk);
    chk("flhz.issue", ex_valid, 1'b1);
    chk("flhz.instr", ex_instr, ADDU6);

    // Reset in the middle of a stall
    issue(LW4, 32'h400);
    @(negedge clk); issue(ADDU6, 32'h404);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; if_valid = 1'b0;
    #1 cmp_all("rststall", empty_slot());
    chk("rststall.id_stall", id_stall, 1'b0);

    // Random traffic against the cycle model
    do_reset();
    m_slot = empty_slot(); m_cnt = 32'h0; prev_stall = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cmp_all($sformatf("rnd%0d", c), m_slot);
`ifdef DECODE_STALL_COUNTER_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 32'h0;
`endif
      chk($sformatf("rnd%0d.perf", c), perf_stall_cnt, exp_cnt);
      if (!prev_stall) begin
        if_valid = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 15) == 0) if_instr = $urandom;
        else begin
          if_instr = {ops[$urandom_range(0, 18)], 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                      16'($urandom)};
          if (if_instr[31:26] == 6'h00) begin
            if_instr[15:11] = 5'($urandom_range(0, 6));
            if_instr[5:0]   = fns[$urandom_range(0, 12)];
          end
        end
        if_pc = $urandom & 32'hFFFF_FFFC;
      end
      rf_data1 = $urandom; rf_data2 = $urandom;
      flush    = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      hz      = ref_hz(m_slot, if_instr);
      m_stall = if_valid && !flush && (hz || !ex_ready);
      chk($sformatf("rnd%0d.id_stall", c), id_stall, m_stall);
      if (flush)              nxt = empty_slot();
      else if (!ex_ready)     nxt = m_slot;
      else if (hz || !if_valid) nxt = empty_slot();
      else                    nxt = ref_decode(if_instr, if_pc, rf_data1, rf_data2);
      m_slot     = nxt;
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      prev_stall = m_stall;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
